// File: rtl/pcie_irq_pkg.sv
// Shared types and helpers for the multi-channel PCIe interrupt mux.
// Holds the FSM state enum, the latched grant record and the MSI vector folding function.
package pcie_irq_pkg;

  localparam int MAX_CH = 32;
  localparam int VEC_W  = 8;
  localparam int IDX_W  = $clog2(MAX_CH);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE,
    HOLD
  } irq_state_e;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [VEC_W-1:0] vec;
  } irq_grant_t;

  // The low mme bits come from base+idx, so channels beyond the allocated
  // vector count alias onto lower vectors. The upper bits come from base.
  function automatic logic [VEC_W-1:0] msi_vector(
    input logic [VEC_W-1:0] base,
    input logic [VEC_W-1:0] idx,
    input logic [2:0]       mme
  );
    logic [VEC_W-1:0] one;
    logic [VEC_W-1:0] mask;
    one  = VEC_W'(1);
    mask = (one << mme) - one;
    return ((base + idx) & mask) | (base & ~mask);
  endfunction

endpackage

// File: rtl/irq_rr_arbiter.sv
// Combinational round-robin pick: the first eligible channel at or after ptr, wrapping around.
module irq_rr_arbiter
  import pcie_irq_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input  logic [NUM_CH-1:0] eligible,
  input  logic [IDX_W-1:0]  ptr,
  output logic [IDX_W-1:0]  grant,
  output logic              valid
);

  localparam int SW = IDX_W + 1;

  logic [2*NUM_CH-1:0] dbl;
  logic [NUM_CH-1:0]   rot;
  logic [SW-1:0]       off;
  logic [SW-1:0]       sum;

  assign dbl = {eligible, eligible};

  // Rotate so that ptr sits at bit 0, then take the lowest set bit.
  always_comb begin
    rot   = NUM_CH'(dbl >> ptr);
    off   = '0;
    valid = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off   = SW'(i);
        valid = 1'b1;
      end
    end
    sum = {1'b0, ptr} + off;
    if (sum >= SW'(NUM_CH)) sum = sum - SW'(NUM_CH);
    grant = sum[IDX_W-1:0];
  end

endmodule

// File: rtl/pcie_irq_mux.sv
// Latches per-channel interrupt requests, arbitrates them round-robin and
// drives the cfg_interrupt / cfg_interrupt_rdy handshake of the PCIe core.
module pcie_irq_mux
  import pcie_irq_pkg::*;
#(
  parameter int              NUM_CH       = 4,
  parameter int              MULTI_VECTOR = 1,
  parameter logic [VEC_W-1:0] VECTOR_BASE = '0,
  parameter int              HOLDOFF      = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  output logic              cfg_interrupt,
  output logic [VEC_W-1:0]  cfg_interrupt_di,
  input  logic              cfg_interrupt_rdy,
  input  logic              cfg_interrupt_msienable,
  input  logic [2:0]        cfg_interrupt_mmenable,
  input  logic [NUM_CH-1:0] ch_req,
  input  logic [NUM_CH-1:0] ch_mask,
  output logic [NUM_CH-1:0] ch_done,
  output logic [NUM_CH-1:0] ch_pending,
  output logic              irq_busy
);

  irq_state_e        state_q;
  irq_grant_t        grant_q;
  logic [NUM_CH-1:0] pending_q;
  logic [NUM_CH-1:0] eligible;
  logic [NUM_CH-1:0] grant_clr;
  logic [IDX_W-1:0]  rr_ptr_q;
  logic [IDX_W-1:0]  ptr_nxt;
  logic [IDX_W-1:0]  arb_idx;
  logic              arb_vld;
  logic [VEC_W-1:0]  arb_vec;
  logic [15:0]       hold_cnt_q;

  assign eligible = pending_q & ~ch_mask;

  irq_rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .eligible (eligible),
    .ptr      (rr_ptr_q),
    .grant    (arb_idx),
    .valid    (arb_vld)
  );

  always_comb begin
    arb_vec = '0;
    if (MULTI_VECTOR != 0 && cfg_interrupt_msienable)
      arb_vec = msi_vector(VECTOR_BASE, VEC_W'(arb_idx), cfg_interrupt_mmenable);
    grant_clr = '0;
    for (int i = 0; i < NUM_CH; i++)
      grant_clr[i] = (state_q == IDLE) && arb_vld && (arb_idx == IDX_W'(i));
  end

  // rr_ptr_q holds the next search start (last grant + 1), so reset value 0
  // makes channel 0 first in line after reset.
  assign ptr_nxt = (grant_q.idx == IDX_W'(NUM_CH - 1)) ? '0 : grant_q.idx + IDX_W'(1);

  assign ch_pending       = pending_q;
  assign cfg_interrupt_di = grant_q.vec;
  assign irq_busy         = (state_q != IDLE);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      pending_q     <= '0;
      rr_ptr_q      <= '0;
      hold_cnt_q    <= '0;
      cfg_interrupt <= 1'b0;
      ch_done       <= '0;
    end else begin
      // A request in the grant cycle re-arms the channel: set wins over clear.
      pending_q <= (pending_q & ~grant_clr) | ch_req;
      ch_done   <= '0;
      case (state_q)
        IDLE: begin
          if (arb_vld) begin
            grant_q       <= '{idx: arb_idx, vec: arb_vec};
            cfg_interrupt <= 1'b1;
            state_q       <= REQ;
          end
        end
        REQ: begin
          if (cfg_interrupt_rdy) begin
            cfg_interrupt <= 1'b0;
            rr_ptr_q      <= ptr_nxt;
            state_q       <= DONE;
            for (int i = 0; i < NUM_CH; i++)
              ch_done[i] <= (grant_q.idx == IDX_W'(i));
          end
        end
        DONE: begin
          hold_cnt_q <= '0;
          state_q    <= (HOLDOFF > 0) ? HOLD : IDLE;
        end
        HOLD: begin
          if (hold_cnt_q == 16'(HOLDOFF - 1)) state_q <= IDLE;
          else hold_cnt_q <= hold_cnt_q + 16'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pcie_irq_mux.sv
// Self-checking bench for pcie_irq_mux: directed scenarios plus a randomized run
// against a transaction-level model of the interrupt mux.
module tb_pcie_irq_mux;

  localparam int         NCH    = 4;
  localparam int         HOLD_N = 5;
  localparam logic [7:0] HBASE  = 8'hF6;

  logic           i_clk = 1'b0;
  logic           i_rst;
  logic           cfg_interrupt, h_cfg;
  logic [7:0]     cfg_interrupt_di, h_di;
  logic           rdy, h_rdy, msien;
  logic [2:0]     mme;
  logic [NCH-1:0] req, mask, done, pend;
  logic [NCH-1:0] h_req, h_mask, h_done, h_pend;
  logic           busy, h_busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 i_clk = ~i_clk;

  pcie_irq_mux #(
    .NUM_CH(NCH), .MULTI_VECTOR(1), .VECTOR_BASE(8'h00), .HOLDOFF(0)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .cfg_interrupt(cfg_interrupt), .cfg_interrupt_di(cfg_interrupt_di),
    .cfg_interrupt_rdy(rdy), .cfg_interrupt_msienable(msien),
    .cfg_interrupt_mmenable(mme), .ch_req(req), .ch_mask(mask),
    .ch_done(done), .ch_pending(pend), .irq_busy(busy)
  );

  pcie_irq_mux #(
    .NUM_CH(NCH), .MULTI_VECTOR(1), .VECTOR_BASE(HBASE), .HOLDOFF(HOLD_N)
  ) dut_h (
    .i_clk(i_clk), .i_rst(i_rst),
    .cfg_interrupt(h_cfg), .cfg_interrupt_di(h_di),
    .cfg_interrupt_rdy(h_rdy), .cfg_interrupt_msienable(msien),
    .cfg_interrupt_mmenable(mme), .ch_req(h_req), .ch_mask(h_mask),
    .ch_done(h_done), .ch_pending(h_pend), .irq_busy(h_busy)
  );

  // Expected MSI data: low m bits are (base+g) modulo 2^m, upper bits from base.
  function automatic int ref_vec(int base, int g, int m, bit en);
    int span;
    if (!en) return 0;
    span = 1 << m;
    return ((base + g) % span) + (base - (base % span));
  endfunction

  function automatic int ref_pick(logic [NCH-1:0] e, int start);
    int c;
    for (int k = 0; k < NCH; k++) begin
      c = (start + k) % NCH;
      if (((e >> c) & 1) != 0) return c;
    end
    return -1;
  endfunction

  task automatic apply_reset();
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic test_reset();
    i_rst = 1'b1; req = '0; mask = '0; rdy = 1'b0; msien = 1'b1; mme = 3'd2;
    h_req = '0; h_mask = '0; h_rdy = 1'b0;
    repeat (2) @(negedge i_clk);
    n_tests++;
    if ({cfg_interrupt, cfg_interrupt_di, done, pend, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_main cfg=%b di=%h done=%b pend=%b busy=%b want all 0",
               cfg_interrupt, cfg_interrupt_di, done, pend, busy);
    end
    n_tests++;
    if ({h_cfg, h_di, h_done, h_pend, h_busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_hold cfg=%b di=%h done=%b pend=%b busy=%b want all 0",
               h_cfg, h_di, h_done, h_pend, h_busy);
    end
    i_rst = 1'b0;
    @(negedge i_clk);
    n_tests++;
    if (cfg_interrupt !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release cfg=%b busy=%b want 0 0", cfg_interrupt, busy);
    end
  endtask

  task automatic test_single();
    req = 4'b0100;
    @(negedge i_clk);
    req = '0;
    n_tests++;
    if (pend !== 4'b0100 || cfg_interrupt !== 1'b0) begin
      n_fail++; $display("FAIL single_pending pend=%b cfg=%b want 0100 0", pend, cfg_interrupt);
    end
    @(negedge i_clk);
    n_tests++;
    if (cfg_interrupt !== 1'b1 || cfg_interrupt_di !== 8'd2 || pend !== 4'b0000 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_rise cfg=%b di=%0d pend=%b busy=%b want 1 2 0000 1",
               cfg_interrupt, cfg_interrupt_di, pend, busy);
    end
    for (int k = 1; k <= 3; k++) begin
      @(negedge i_clk);
      n_tests++;
      if (cfg_interrupt !== 1'b1 || cfg_interrupt_di !== 8'd2 || done !== 4'b0000) begin
        n_fail++;
        $display("FAIL single_wait%0d cfg=%b di=%0d done=%b want 1 2 0000", k, cfg_interrupt, cfg_interrupt_di, done);
      end
    end
    rdy = 1'b1;
    @(negedge i_clk);
    rdy = 1'b0;
    n_tests++;
    if (cfg_interrupt !== 1'b0 || done !== 4'b0100 || busy !== 1'b1) begin
      n_fail++; $display("FAIL single_done cfg=%b done=%b busy=%b want 0 0100 1", cfg_interrupt, done, busy);
    end
    @(negedge i_clk);
    n_tests++;
    if (done !== 4'b0000 || busy !== 1'b0 || pend !== 4'b0000) begin
      n_fail++; $display("FAIL single_after done=%b busy=%b pend=%b want 0000 0 0000", done, busy, pend);
    end
  endtask

  task automatic test_round_robin();
    int nd, nr, last_rise;
    logic prev;
    apply_reset();
    rdy = 1'b1;
    for (int b = 0; b < 2; b++) begin
      req = 4'b1111;
      @(negedge i_clk);
      req = '0;
      nd = 0; nr = 0; last_rise = 0; prev = 1'b0;
      for (int c = 0; c < 40 && nd < 4; c++) begin
        if (cfg_interrupt && !prev) begin
          n_tests++;
          if (cfg_interrupt_di !== 8'(ref_vec(0, nr, 2, 1'b1))) begin
            n_fail++; $display("FAIL rr_di burst%0d #%0d got %0d want %0d", b, nr, cfg_interrupt_di, nr);
          end
          if (nr > 0) begin
            n_tests++;
            if (c - last_rise != 3) begin
              n_fail++; $display("FAIL rr_spacing burst%0d got %0d cycles want 3", b, c - last_rise);
            end
          end
          last_rise = c;
          nr++;
        end
        if (done !== '0) begin
          n_tests++;
          if (done !== 4'(1 << nd)) begin
            n_fail++; $display("FAIL rr_order burst%0d #%0d done=%b want %b", b, nd, done, 4'(1 << nd));
          end
          nd++;
        end
        prev = cfg_interrupt;
        @(negedge i_clk);
      end
      n_tests++;
      if (nd != 4) begin
        n_fail++; $display("FAIL rr_timeout burst%0d got %0d done pulses want 4", b, nd);
      end
    end
    rdy = 1'b0;
  endtask

  task automatic test_mask();
    logic [NCH-1:0] seen;
    mask = 4'b0010; rdy = 1'b1; req = 4'b1010;
    @(negedge i_clk);
    req = '0;
    seen = '0;
    repeat (12) begin
      seen |= done;
      @(negedge i_clk);
    end
    n_tests++;
    if (seen !== 4'b1000 || pend !== 4'b0010) begin
      n_fail++; $display("FAIL mask_served seen=%b pend=%b want 1000 0010", seen, pend);
    end
    mask = '0;
    seen = '0;
    repeat (12) begin
      seen |= done;
      @(negedge i_clk);
    end
    n_tests++;
    if (seen !== 4'b0010 || pend !== 4'b0000) begin
      n_fail++; $display("FAIL mask_cleared seen=%b pend=%b want 0010 0000", seen, pend);
    end
    rdy = 1'b0;
  endtask

  task automatic test_vector();
    mme = 3'd1; rdy = 1'b0; req = 4'b1000;
    @(negedge i_clk);
    req = '0;
    for (int c = 0; c < 6 && cfg_interrupt !== 1'b1; c++) @(negedge i_clk);
    n_tests++;
    if (cfg_interrupt !== 1'b1 || cfg_interrupt_di !== 8'(ref_vec(0, 3, 1, 1'b1))) begin
      n_fail++; $display("FAIL vec_alias cfg=%b di=%0d want 1 %0d", cfg_interrupt, cfg_interrupt_di, ref_vec(0, 3, 1, 1'b1));
    end
    mme = 3'd3;
    @(negedge i_clk);
    n_tests++;
    if (cfg_interrupt_di !== 8'd1) begin
      n_fail++; $display("FAIL vec_inflight di=%0d want 1", cfg_interrupt_di);
    end
    rdy = 1'b1;
    @(negedge i_clk);
    rdy = 1'b0;
    @(negedge i_clk);
    msien = 1'b0; req = 4'b1000;
    @(negedge i_clk);
    req = '0;
    for (int c = 0; c < 6 && cfg_interrupt !== 1'b1; c++) @(negedge i_clk);
    n_tests++;
    if (cfg_interrupt !== 1'b1 || cfg_interrupt_di !== 8'd0) begin
      n_fail++; $display("FAIL vec_msi_off cfg=%b di=%0d want 1 0", cfg_interrupt, cfg_interrupt_di);
    end
    rdy = 1'b1;
    @(negedge i_clk);
    rdy = 1'b0;
    repeat (2) @(negedge i_clk);
    msien = 1'b1; mme = 3'd2;
  endtask

  task automatic test_holdoff();
    int gap;
    h_req = 4'b0001;
    @(negedge i_clk);
    n_tests++;
    if (h_pend !== 4'b0001 || h_cfg !== 1'b0) begin
      n_fail++; $display("FAIL hold_pending pend=%b cfg=%b want 0001 0", h_pend, h_cfg);
    end
    @(negedge i_clk);
    h_req = '0; h_rdy = 1'b1;
    n_tests++;
    if (h_cfg !== 1'b1 || h_pend !== 4'b0001 || h_di !== 8'(ref_vec(int'(HBASE), 0, 2, 1'b1))) begin
      n_fail++;
      $display("FAIL hold_first cfg=%b pend=%b di=%0d want 1 0001 %0d",
               h_cfg, h_pend, h_di, ref_vec(int'(HBASE), 0, 2, 1'b1));
    end
    @(negedge i_clk);
    n_tests++;
    if (h_done !== 4'b0001 || h_cfg !== 1'b0) begin
      n_fail++; $display("FAIL hold_done done=%b cfg=%b want 0001 0", h_done, h_cfg);
    end
    gap = 0;
    for (int c = 1; c <= 20 && gap == 0; c++) begin
      @(negedge i_clk);
      if (c == 3) begin
        n_tests++;
        if (h_busy !== 1'b1 || h_cfg !== 1'b0) begin
          n_fail++; $display("FAIL hold_busy busy=%b cfg=%b want 1 0", h_busy, h_cfg);
        end
      end
      if (h_cfg === 1'b1) gap = c;
    end
    n_tests++;
    if (gap != HOLD_N + 2) begin
      n_fail++; $display("FAIL hold_gap got %0d cycles want %0d", gap, HOLD_N + 2);
    end
    repeat (2) @(negedge i_clk);
    h_rdy = 1'b0;
    repeat (HOLD_N + 2) @(negedge i_clk);
    n_tests++;
    if (h_pend !== 4'b0000 || h_busy !== 1'b0) begin
      n_fail++; $display("FAIL hold_end pend=%b busy=%b want 0000 0", h_pend, h_busy);
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    rdy = 1'b0; req = 4'b0110;
    @(negedge i_clk);
    req = 4'b1000;
    @(negedge i_clk);
    req = '0;
    for (int c = 0; c < 6 && cfg_interrupt !== 1'b1; c++) @(negedge i_clk);
    n_tests++;
    if (cfg_interrupt !== 1'b1 || $countones(pend) != 2) begin
      n_fail++; $display("FAIL rmid_setup cfg=%b pend=%b want 1 and two pending", cfg_interrupt, pend);
    end
    #2 i_rst = 1'b1;
    #1;
    n_tests++;
    if (cfg_interrupt !== 1'b0 || pend !== 4'b0000 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rmid_async cfg=%b pend=%b busy=%b want 0 0000 0", cfg_interrupt, pend, busy);
    end
    @(negedge i_clk);
    i_rst = 1'b0; rdy = 1'b1;
    bad = 0;
    repeat (10) begin
      @(negedge i_clk);
      if (done !== '0 || cfg_interrupt !== 1'b0) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++; $display("FAIL rmid_quiet got %0d cycles with activity want 0", bad);
    end
    rdy = 1'b0;
  endtask

  // Transaction-level model: a set of pending channels, an in-flight grant and
  // the last served channel; checks every cycle against the DUT.
  task automatic test_random();
    logic [NCH-1:0] prev_pend, prev_req, prev_mask, exp_pend, exp_done, elig;
    logic [2:0]     prev_mme;
    logic           prev_msien, prev_rdy, prev_cfg, prev_can;
    logic           exp_rise, exp_cfg, exp_busy, done_now;
    int             last_g, cur_g, cur_di, g;
    req = '0; mask = '0; rdy = 1'b0; msien = 1'b1; mme = 3'd2;
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    prev_pend = '0; prev_req = '0; prev_mask = '0; prev_mme = mme; prev_msien = msien;
    prev_rdy = 1'b0; prev_cfg = 1'b0; prev_can = 1'b1;
    last_g = NCH - 1; cur_g = 0; cur_di = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge i_clk);
      elig     = prev_pend & ~prev_mask;
      exp_rise = prev_can && (elig != '0);
      g        = 0;
      if (exp_rise) begin
        g      = ref_pick(elig, (last_g + 1) % NCH);
        cur_g  = g;
        cur_di = ref_vec(0, g, int'(prev_mme), prev_msien);
      end
      exp_pend = prev_pend;
      if (exp_rise) exp_pend = exp_pend & ~4'(1 << g);
      exp_pend = exp_pend | prev_req;
      done_now = prev_cfg && prev_rdy;
      exp_cfg  = exp_rise || (prev_cfg && !prev_rdy);
      exp_done = done_now ? 4'(1 << cur_g) : 4'b0000;
      if (done_now) last_g = cur_g;
      exp_busy = exp_cfg || done_now;

      n_tests++;
      if (cfg_interrupt !== exp_cfg) begin
        n_fail++; $display("FAIL rnd_cfg cyc%0d got %b want %b", cyc, cfg_interrupt, exp_cfg);
      end
      n_tests++;
      if (done !== exp_done) begin
        n_fail++; $display("FAIL rnd_done cyc%0d got %b want %b", cyc, done, exp_done);
      end
      n_tests++;
      if (pend !== exp_pend) begin
        n_fail++; $display("FAIL rnd_pend cyc%0d got %b want %b", cyc, pend, exp_pend);
      end
      n_tests++;
      if (busy !== exp_busy) begin
        n_fail++; $display("FAIL rnd_busy cyc%0d got %b want %b", cyc, busy, exp_busy);
      end
      if (exp_cfg) begin
        n_tests++;
        if (cfg_interrupt_di !== 8'(cur_di)) begin
          n_fail++; $display("FAIL rnd_di cyc%0d got %0d want %0d", cyc, cfg_interrupt_di, cur_di);
        end
      end

      req = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      if ($urandom_range(0, 15) == 0) mask = 4'($urandom) & 4'($urandom);
      rdy = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 19) == 0) mme = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 19) == 0) msien = ~msien;

      prev_pend = exp_pend; prev_req = req; prev_mask = mask; prev_mme = mme;
      prev_msien = msien; prev_rdy = rdy; prev_cfg = exp_cfg; prev_can = !exp_busy;
    end
    req = '0; mask = '0; rdy = 1'b0; msien = 1'b1;
  endtask

  initial begin
    i_rst = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_mask();
    test_vector();
    test_holdoff();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
